// File: rtl/fwd_pkg.sv
// Shared constants and types for the in-order forwarding sequencer.
package fwd_pkg;

  localparam int DEFAULT_N_VMS = 4;
  localparam int DEFAULT_DEPTH = 8;

  // Per-VM count of rejected packets still sitting in the order queue.
  localparam int                DROP_W   = 2;
  localparam logic [DROP_W-1:0] DROP_SAT = 2'd3;

  typedef logic [DROP_W-1:0] drop_cnt_t;

  // What the head of the order queue does this cycle.
  typedef enum logic [1:0] {
    HEAD_IDLE,   // queue empty
    HEAD_SKIP,   // head was rejected by its VM: pop without serving
    HEAD_SERVE   // head is live: the forwarder may read it
  } head_act_e;

endpackage : fwd_pkg

// File: rtl/fwd_order_sched_if.sv
// Dispatch/reject/forward handshake between snoopsplit, the sequencer and fwdcombine.
interface fwd_order_sched_if #(
  parameter int ID_WIDTH  = 2,
  parameter int CNT_WIDTH = 4
);

  logic                 dispatch_valid;
  logic [ID_WIDTH-1:0]  dispatch_id;
  logic                 dispatch_ready;
  logic                 reject_valid;
  logic [ID_WIDTH-1:0]  reject_id;
  logic                 forwarder_done;
  logic [ID_WIDTH-1:0]  sel;
  logic                 sel_valid;
  logic [CNT_WIDTH-1:0] queue_count;
  logic                 overflow_err;
  logic                 protocol_err;

  // Environment side: snoopsplit, VM filters and forwarder.
  modport master (
    output dispatch_valid, dispatch_id, reject_valid, reject_id, forwarder_done,
    input  dispatch_ready, sel, sel_valid, queue_count, overflow_err, protocol_err
  );

  // Sequencer side.
  modport slave (
    input  dispatch_valid, dispatch_id, reject_valid, reject_id, forwarder_done,
    output dispatch_ready, sel, sel_valid, queue_count, overflow_err, protocol_err
  );

endinterface : fwd_order_sched_if

// File: rtl/fwd_order_fifo.sv
// Circular FIFO of VM IDs recording dispatch order. Besides the current head it
// exposes the head as it will stand after this cycle's push/pop, so the parent
// can register sel without an extra cycle of latency.
module fwd_order_fifo
  import fwd_pkg::*;
#(
  parameter int DEPTH    = DEFAULT_DEPTH,
  parameter int ID_WIDTH = 2
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      i_push,
  input  logic [ID_WIDTH-1:0]       i_push_data,
  input  logic                      i_pop,
  output logic [ID_WIDTH-1:0]       o_head,
  output logic                      o_full,
  output logic                      o_empty,
  output logic [$clog2(DEPTH):0]    o_count,
  output logic                      o_nxt_empty,
  output logic [ID_WIDTH-1:0]       o_nxt_head
);

  localparam int            AW       = $clog2(DEPTH);
  localparam logic [AW:0]   FULL_CNT = (AW+1)'(DEPTH);

  // Extra MSB on each pointer tells full from empty when the indices match.
  logic [AW:0]         r_rd_ptr;
  logic [AW:0]         r_wr_ptr;
  logic [ID_WIDTH-1:0] r_mem [DEPTH];

  logic                w_do_push;
  logic                w_do_pop;
  logic [AW-1:0]       w_rd_idx_nxt;
  logic [AW:0]         w_nxt_count;

  assign o_count      = r_wr_ptr - r_rd_ptr;
  assign o_empty      = (r_wr_ptr == r_rd_ptr);
  assign o_full       = (o_count == FULL_CNT);
  assign w_do_push    = i_push && !o_full;
  assign w_do_pop     = i_pop && !o_empty;
  assign o_head       = r_mem[r_rd_ptr[AW-1:0]];
  assign w_rd_idx_nxt = r_rd_ptr[AW-1:0] + AW'(1);
  assign w_nxt_count  = o_count + (AW+1)'(w_do_push) - (AW+1)'(w_do_pop);
  assign o_nxt_empty  = (w_nxt_count == '0);

  // Head after this cycle: second entry on pop, else current head, else the incoming ID.
  always_comb begin
    o_nxt_head = i_push_data;
    if (w_do_pop) begin
      if (o_count > (AW+1)'(1)) o_nxt_head = r_mem[w_rd_idx_nxt];
    end else if (!o_empty) begin
      o_nxt_head = o_head;
    end
  end

  // Pointer update.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    if (!rst_n) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
    end else begin
      if (w_do_push) r_wr_ptr <= r_wr_ptr + (AW+1)'(1);
      if (w_do_pop)  r_rd_ptr <= r_rd_ptr + (AW+1)'(1);
    end
  end

  // Entry storage.
  // NOTE: storage has no reset; the pointers alone decide which entries are live.
  always_ff @(posedge clk) begin
    if (w_do_push) r_mem[r_wr_ptr[AW-1:0]] <= i_push_data;
  end

endmodule : fwd_order_fifo

// File: rtl/fwd_order_sched.sv
// In-order forwarding sequencer: records dispatch order, skips packets their VM
// rejected, and drives the fwdcombine select so VMs drain in arrival order.
module fwd_order_sched
  import fwd_pkg::*;
#(
  parameter int N_VMS     = DEFAULT_N_VMS,
  parameter int ID_WIDTH  = $clog2(N_VMS),
  parameter int DEPTH     = DEFAULT_DEPTH,
  parameter int CNT_WIDTH = $clog2(DEPTH) + 1
) (
  input  logic             clk,
  input  logic             rst_n,
  fwd_order_sched_if.slave bus
);

  logic [ID_WIDTH-1:0]  w_head;
  logic [ID_WIDTH-1:0]  w_nxt_head;
  logic                 w_empty;
  logic                 w_full;
  logic                 w_nxt_empty;
  logic [CNT_WIDTH-1:0] w_count;
  logic                 w_push;
  logic                 w_pop;
  logic                 w_done_pop;
  logic                 w_sat_hit;
  head_act_e            w_act;
  drop_cnt_t            w_drop_nxt [N_VMS];

  drop_cnt_t            r_drop_cnt [N_VMS];
  logic [ID_WIDTH-1:0]  r_sel;
  logic                 r_sel_valid;
  logic                 r_overflow_err;
  logic                 r_protocol_err;

  fwd_order_fifo #(
    .DEPTH    (DEPTH),
    .ID_WIDTH (ID_WIDTH)
  ) u_fifo (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_push      (w_push),
    .i_push_data (bus.dispatch_id),
    .i_pop       (w_pop),
    .o_head      (w_head),
    .o_full      (w_full),
    .o_empty     (w_empty),
    .o_count     (w_count),
    .o_nxt_empty (w_nxt_empty),
    .o_nxt_head  (w_nxt_head)
  );

  // Classify the current head: skip if its VM owes a drop, otherwise serve.
  always_comb begin
    // NOTE: default assigned first so every path drives w_act and no latch is inferred.
    w_act = HEAD_IDLE;
    if (!w_empty) w_act = (r_drop_cnt[w_head] != '0) ? HEAD_SKIP : HEAD_SERVE;
  end

  // A served head only leaves on forwarder_done; sel_valid=1 already implies SERVE.
  assign w_done_pop = bus.forwarder_done && r_sel_valid;
  assign w_pop      = (w_act == HEAD_SKIP) || w_done_pop;
  // Ready is taken pre-pop, so a full queue refuses a push even while popping.
  assign w_push     = bus.dispatch_valid && !w_full;

  // Drop counter next state: reject increments, skip decrements, both cancel.
  always_comb begin
    w_sat_hit = 1'b0;
    for (int i = 0; i < N_VMS; i++) begin
      w_drop_nxt[i] = r_drop_cnt[i];
      if (bus.reject_valid && (bus.reject_id == ID_WIDTH'(i)) &&
          !((w_act == HEAD_SKIP) && (w_head == ID_WIDTH'(i)))) begin
        if (r_drop_cnt[i] == DROP_SAT) w_sat_hit = 1'b1;
        else                           w_drop_nxt[i] = r_drop_cnt[i] + DROP_W'(1);
      end else if ((w_act == HEAD_SKIP) && (w_head == ID_WIDTH'(i)) &&
                   !(bus.reject_valid && (bus.reject_id == ID_WIDTH'(i)))) begin
        w_drop_nxt[i] = r_drop_cnt[i] - DROP_W'(1);
      end
    end
  end

  // Drop counters.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N_VMS; i++) r_drop_cnt[i] <= '0;
    end else begin
      for (int i = 0; i < N_VMS; i++) r_drop_cnt[i] <= w_drop_nxt[i];
    end
  end

  // Select register, evaluated on the post-pop/post-push head; held while empty.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sel       <= '0;
      r_sel_valid <= 1'b0;
    end else begin
      r_sel_valid <= !w_nxt_empty && (w_drop_nxt[w_nxt_head] == '0);
      if (!w_nxt_empty) r_sel <= w_nxt_head;
    end
  end

  // Sticky error flags.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_overflow_err <= 1'b0;
      r_protocol_err <= 1'b0;
    end else begin
      if ((bus.dispatch_valid && w_full) || w_sat_hit) r_overflow_err <= 1'b1;
      if (bus.forwarder_done && !r_sel_valid)          r_protocol_err <= 1'b1;
    end
  end

  assign bus.dispatch_ready = !w_full;
  assign bus.sel            = r_sel;
  assign bus.sel_valid      = r_sel_valid;
  assign bus.queue_count    = w_count;
  assign bus.overflow_err   = r_overflow_err;
  assign bus.protocol_err   = r_protocol_err;

endmodule : fwd_order_sched

// File: tb/tb_fwd_order_sched.sv
// Bench for fwd_order_sched: directed scenarios followed by random traffic
// checked against a queue-level reference model.
module tb_fwd_order_sched;

  localparam int N_VMS     = 4;
  localparam int ID_WIDTH  = 2;
  localparam int DEPTH     = 8;
  localparam int CNT_WIDTH = 4;

  logic clk   = 1'b0;
  logic rst_n = 1'b0;

  int n_vec = 0;
  int n_err = 0;

  // Reference model state.
  int mq[$];
  int m_drop [N_VMS];
  bit m_sv;
  int m_sel;
  bit m_ovf;
  bit m_perr;

  fwd_order_sched_if #(.ID_WIDTH(ID_WIDTH), .CNT_WIDTH(CNT_WIDTH)) bus ();

  fwd_order_sched #(
    .N_VMS     (N_VMS),
    .ID_WIDTH  (ID_WIDTH),
    .DEPTH     (DEPTH),
    .CNT_WIDTH (CNT_WIDTH)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clear_inputs();
    bus.dispatch_valid = 1'b0;
    bus.dispatch_id    = '0;
    bus.reject_valid   = 1'b0;
    bus.reject_id      = '0;
    bus.forwarder_done = 1'b0;
  endtask

  // Apply one cycle of inputs; returns 1 ns after the edge.
  task automatic step(input bit dv, input logic [1:0] did, input bit rv,
                      input logic [1:0] rid, input bit fd);
    bus.dispatch_valid = dv;
    bus.dispatch_id    = did;
    bus.reject_valid   = rv;
    bus.reject_id      = rid;
    bus.forwarder_done = fd;
    @(posedge clk);
    #1;
    clear_inputs();
  endtask

  task automatic do_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic model_reset();
    mq.delete();
    for (int i = 0; i < N_VMS; i++) m_drop[i] = 0;
    m_sv = 0; m_sel = 0; m_ovf = 0; m_perr = 0;
  endtask

  // One clock of the sequencer expressed as queue operations.
  task automatic model_step(input bit dv, input int did, input bit rv, input int rid, input bit fd);
    bit full, skip, serve_pop;
    int h;
    full = (mq.size() == DEPTH);
    skip = 0;
    h    = -1;
    if (mq.size() != 0) begin
      h    = mq[0];
      skip = (m_drop[h] != 0);
    end
    serve_pop = fd && m_sv;
    if (fd && !m_sv) m_perr = 1;
    if (dv && full) m_ovf = 1;
    if (rv && !(skip && rid == h)) begin
      if (m_drop[rid] == 3) m_ovf = 1;
      else                  m_drop[rid]++;
    end
    if (skip && !(rv && rid == h)) m_drop[h]--;
    if (skip || serve_pop) void'(mq.pop_front());
    if (dv && !full) mq.push_back(did);
    if (mq.size() != 0) begin
      m_sel = mq[0];
      m_sv  = (m_drop[mq[0]] == 0);
    end else begin
      m_sv = 0;
    end
  endtask

  task automatic test_reset();
    clear_inputs();
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    n_vec++; if (bus.sel !== 2'd0) begin n_err++; $display("FAIL reset_sel: got %0d want 0", bus.sel); end
    n_vec++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL reset_sel_valid: got %0b want 0", bus.sel_valid); end
    n_vec++; if (bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %0b want 1", bus.dispatch_ready); end
    n_vec++; if (bus.queue_count !== 4'd0) begin n_err++; $display("FAIL reset_count: got %0d want 0", bus.queue_count); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL reset_ovf: got %0b want 0", bus.overflow_err); end
    n_vec++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL reset_perr: got %0b want 0", bus.protocol_err); end
    rst_n = 1'b1;
  endtask

  task automatic test_order();
    step(1, 2'd2, 0, 0, 0);
    n_vec++; if (bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL order_first_valid: got %0b want 1", bus.sel_valid); end
    n_vec++; if (bus.sel !== 2'd2) begin n_err++; $display("FAIL order_first_sel: got %0d want 2", bus.sel); end
    step(1, 2'd0, 0, 0, 0);
    step(1, 2'd3, 0, 0, 0);
    n_vec++; if (bus.queue_count !== 4'd3) begin n_err++; $display("FAIL order_count3: got %0d want 3", bus.queue_count); end
    n_vec++; if (bus.sel !== 2'd2) begin n_err++; $display("FAIL order_hold_sel: got %0d want 2", bus.sel); end
    step(0, 0, 0, 0, 1);
    n_vec++; if (bus.sel !== 2'd0 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL order_second: got sel=%0d v=%0b want sel=0 v=1", bus.sel, bus.sel_valid); end
    step(0, 0, 0, 0, 1);
    n_vec++; if (bus.sel !== 2'd3 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL order_third: got sel=%0d v=%0b want sel=3 v=1", bus.sel, bus.sel_valid); end
    step(0, 0, 0, 0, 1);
    n_vec++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL order_empty_valid: got %0b want 0", bus.sel_valid); end
    n_vec++; if (bus.queue_count !== 4'd0) begin n_err++; $display("FAIL order_empty_count: got %0d want 0", bus.queue_count); end
    n_vec++; if (bus.sel !== 2'd3) begin n_err++; $display("FAIL order_sel_held: got %0d want 3", bus.sel); end
    n_vec++; if (bus.protocol_err !== 1'b0) begin n_err++; $display("FAIL order_perr: got %0b want 0", bus.protocol_err); end
  endtask

  task automatic test_reject();
    step(1, 2'd1, 0, 0, 0);
    step(1, 2'd2, 0, 0, 0);
    n_vec++; if (bus.sel !== 2'd1 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL rej_serve1: got sel=%0d v=%0b want sel=1 v=1", bus.sel, bus.sel_valid); end
    step(0, 0, 1, 2'd1, 0);
    n_vec++; if (bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL rej_drop_valid: got %0b want 0", bus.sel_valid); end
    n_vec++; if (bus.queue_count !== 4'd2) begin n_err++; $display("FAIL rej_count2: got %0d want 2", bus.queue_count); end
    step(0, 0, 0, 0, 0);
    n_vec++; if (bus.sel !== 2'd2 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL rej_next: got sel=%0d v=%0b want sel=2 v=1", bus.sel, bus.sel_valid); end
    n_vec++; if (bus.queue_count !== 4'd1) begin n_err++; $display("FAIL rej_count1: got %0d want 1", bus.queue_count); end
    step(0, 0, 0, 0, 1);
    // A fresh packet for VM 1 must be served, proving its drop counter is back to 0.
    step(1, 2'd1, 0, 0, 0);
    n_vec++; if (bus.sel !== 2'd1 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL rej_cnt_cleared: got sel=%0d v=%0b want sel=1 v=1", bus.sel, bus.sel_valid); end
    step(0, 0, 0, 0, 1);
  endtask

  task automatic test_full();
    do_reset();
    for (int i = 0; i < DEPTH; i++) step(1, 2'(i % 4), 0, 0, 0);
    n_vec++; if (bus.dispatch_ready !== 1'b0) begin n_err++; $display("FAIL full_ready: got %0b want 0", bus.dispatch_ready); end
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL full_ovf_early: got %0b want 0", bus.overflow_err); end
    step(1, 2'd2, 0, 0, 0);
    n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL full_ovf: got %0b want 1", bus.overflow_err); end
    n_vec++; if (bus.queue_count !== 4'd8) begin n_err++; $display("FAIL full_count8: got %0d want 8", bus.queue_count); end
    // Push refused (ready is pre-pop) while the done pops: one slot frees up.
    step(1, 2'd1, 0, 0, 1);
    n_vec++; if (bus.queue_count !== 4'd7) begin n_err++; $display("FAIL full_pushpop_count: got %0d want 7", bus.queue_count); end
    n_vec++; if (bus.sel !== 2'd1 || bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL full_pushpop_sel: got sel=%0d rdy=%0b want sel=1 rdy=1", bus.sel, bus.dispatch_ready); end
    step(1, 2'd1, 0, 0, 0);
    n_vec++; if (bus.queue_count !== 4'd8) begin n_err++; $display("FAIL full_refill: got %0d want 8", bus.queue_count); end
  endtask

  task automatic test_saturate();
    do_reset();
    for (int i = 0; i < 3; i++) step(0, 0, 1, 2'd3, 0);
    n_vec++; if (bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL sat_early: got %0b want 0", bus.overflow_err); end
    step(0, 0, 1, 2'd3, 0);
    n_vec++; if (bus.overflow_err !== 1'b1) begin n_err++; $display("FAIL sat_ovf: got %0b want 1", bus.overflow_err); end
    for (int i = 0; i < 3; i++) step(1, 2'd3, 0, 0, 0);
    n_vec++; if (bus.sel_valid !== 1'b0 || bus.queue_count !== 4'd1) begin n_err++; $display("FAIL sat_skipping: got v=%0b cnt=%0d want v=0 cnt=1", bus.sel_valid, bus.queue_count); end
    step(1, 2'd3, 0, 0, 0);
    n_vec++; if (bus.sel !== 2'd3 || bus.sel_valid !== 1'b1) begin n_err++; $display("FAIL sat_fourth: got sel=%0d v=%0b want sel=3 v=1", bus.sel, bus.sel_valid); end
    n_vec++; if (bus.queue_count !== 4'd1) begin n_err++; $display("FAIL sat_count: got %0d want 1", bus.queue_count); end
    step(0, 0, 0, 0, 1);
    n_vec++; if (bus.queue_count !== 4'd0) begin n_err++; $display("FAIL sat_drain: got %0d want 0", bus.queue_count); end
  endtask

  task automatic test_protocol();
    do_reset();
    step(0, 0, 0, 0, 1);
    n_vec++; if (bus.protocol_err !== 1'b1) begin n_err++; $display("FAIL proto_err: got %0b want 1", bus.protocol_err); end
    n_vec++; if (bus.queue_count !== 4'd0) begin n_err++; $display("FAIL proto_count: got %0d want 0", bus.queue_count); end
  endtask

  task automatic test_async_reset();
    for (int i = 0; i < 5; i++) step(1, 2'd1, 0, 0, 0);
    n_vec++; if (bus.queue_count !== 4'd5) begin n_err++; $display("FAIL arst_pre_count: got %0d want 5", bus.queue_count); end
    #2;
    rst_n = 1'b0;
    #1;
    n_vec++; if (bus.queue_count !== 4'd0) begin n_err++; $display("FAIL arst_count: got %0d want 0", bus.queue_count); end
    n_vec++; if (bus.sel !== 2'd0 || bus.sel_valid !== 1'b0) begin n_err++; $display("FAIL arst_sel: got sel=%0d v=%0b want sel=0 v=0", bus.sel, bus.sel_valid); end
    n_vec++; if (bus.dispatch_ready !== 1'b1) begin n_err++; $display("FAIL arst_ready: got %0b want 1", bus.dispatch_ready); end
    n_vec++; if (bus.protocol_err !== 1'b0 || bus.overflow_err !== 1'b0) begin n_err++; $display("FAIL arst_errs: got perr=%0b ovf=%0b want 0 0", bus.protocol_err, bus.overflow_err); end
    @(posedge clk);
    #1;
    rst_n = 1'b1;
  endtask

  task automatic test_random(input int n_cycles);
    bit dv, rv, fd;
    int did, rid;
    bit prev_valid;
    int prev_sel;
    do_reset();
    model_reset();
    prev_valid = 0;
    prev_sel   = 0;
    for (int c = 0; c < n_cycles; c++) begin
      dv  = ($urandom_range(99) < 45);
      did = $urandom_range(N_VMS - 1);
      rv  = ($urandom_range(99) < 6);
      rid = $urandom_range(N_VMS - 1);
      fd  = m_sv && ($urandom_range(99) < 55);
      bus.dispatch_valid = dv;
      bus.dispatch_id    = 2'(did);
      bus.reject_valid   = rv;
      bus.reject_id      = 2'(rid);
      bus.forwarder_done = fd;
      @(posedge clk);
      model_step(dv, did, rv, rid, fd);
      #1;
      clear_inputs();
      n_vec++; if (bus.sel_valid !== m_sv) begin n_err++; $display("FAIL rnd_sel_valid c=%0d: got %0b want %0b", c, bus.sel_valid, m_sv); end
      n_vec++; if (bus.sel !== 2'(m_sel)) begin n_err++; $display("FAIL rnd_sel c=%0d: got %0d want %0d", c, bus.sel, m_sel); end
      n_vec++; if (bus.queue_count !== 4'(mq.size())) begin n_err++; $display("FAIL rnd_count c=%0d: got %0d want %0d", c, bus.queue_count, mq.size()); end
      n_vec++; if (bus.dispatch_ready !== (mq.size() != DEPTH)) begin n_err++; $display("FAIL rnd_ready c=%0d: got %0b want %0b", c, bus.dispatch_ready, mq.size() != DEPTH); end
      n_vec++; if (bus.overflow_err !== m_ovf) begin n_err++; $display("FAIL rnd_ovf c=%0d: got %0b want %0b", c, bus.overflow_err, m_ovf); end
      n_vec++; if (bus.protocol_err !== m_perr) begin n_err++; $display("FAIL rnd_perr c=%0d: got %0b want %0b", c, bus.protocol_err, m_perr); end
      // A packet being served keeps its select until forwarder_done.
      if (prev_valid && !fd && bus.sel_valid) begin
        n_vec++; if (bus.sel !== 2'(prev_sel)) begin n_err++; $display("FAIL rnd_sel_stable c=%0d: got %0d want %0d", c, bus.sel, prev_sel); end
      end
      prev_valid = bus.sel_valid;
      prev_sel   = int'(bus.sel);
    end
  endtask

  initial begin
    clear_inputs();
    test_reset();
    test_order();
    test_reject();
    test_full();
    test_saturate();
    test_protocol();
    test_async_reset();
    test_random(10000);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule : tb_fwd_order_sched
